// File: rtl/memy_arbiter.sv
// Two-requester (convolution core / host) arbiter for the single-port memY RAM,
// with a core burst lock. Define MEMY_ARB_STATS_EN to build saturating grant counters.
module memy_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    input  logic                  core_lock_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic                  core_gnt_o,
    output logic                  host_gnt_o,
    output logic                  core_rvalid_o,
    output logic                  host_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic [15:0]           core_cnt_o,
    output logic [15:0]           host_cnt_o
);

    typedef enum logic {ARB, CORE_LOCK} state_t;

    state_t                  state_reg, state_next;
    logic                    rr_ptr_reg, rr_ptr_next;
    logic                    core_gnt, host_gnt;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    wr_gnt, rd_gnt;
    logic [ADDR_WIDTH-1:0]   waddr_reg, raddr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [1:0]              gnt_vec;
    logic [1:0]              rvalid_reg;

    // Grants are masked while rst is high so nothing reaches the RAM during reset.
    always_comb begin
        core_gnt    = 1'b0;
        host_gnt    = 1'b0;
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        if (!rst) begin
            case (state_reg)
                ARB: begin
                    if (core_req_i && host_req_i) begin
                        core_gnt = rr_ptr_reg;
                        host_gnt = !rr_ptr_reg;
                    end else begin
                        core_gnt = core_req_i;
                        host_gnt = host_req_i;
                    end
                    if (core_gnt && core_lock_i)
                        state_next = CORE_LOCK;
                end
                CORE_LOCK: begin
                    core_gnt = core_req_i;
                    if (!core_lock_i)
                        state_next = ARB;
                end
                default: state_next = ARB;
            endcase
            if (core_gnt)
                rr_ptr_next = 1'b0;
            else if (host_gnt)
                rr_ptr_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ARB;
            rr_ptr_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        sel_we    = host_we_i;
        sel_addr  = host_addr_i;
        sel_wdata = host_wdata_i;
        if (core_gnt) begin
            sel_we    = core_we_i;
            sel_addr  = core_addr_i;
            sel_wdata = core_wdata_i;
        end
    end

    assign wr_gnt  = (core_gnt || host_gnt) && sel_we;
    assign rd_gnt  = (core_gnt || host_gnt) && !sel_we;
    assign gnt_vec = {host_gnt, core_gnt};

    // Idle cycles replay the last address so the RAM port does not toggle.
    assign ram_we_o    = wr_gnt;
    assign ram_waddr_o = wr_gnt ? sel_addr  : waddr_reg;
    assign ram_wdata_o = wr_gnt ? sel_wdata : wdata_reg;
    assign ram_raddr_o = rd_gnt ? sel_addr  : raddr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_reg <= '0;
            raddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            if (wr_gnt) begin
                waddr_reg <= sel_addr;
                wdata_reg <= sel_wdata;
            end
            if (rd_gnt)
                raddr_reg <= sel_addr;
        end
    end

    // Index 0 is the core, index 1 the host.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    rvalid_reg[gi] <= 1'b0;
                else
                    rvalid_reg[gi] <= gnt_vec[gi] && !sel_we;
            end
        end
    endgenerate

    assign core_gnt_o    = core_gnt;
    assign host_gnt_o    = host_gnt;
    assign core_rvalid_o = rvalid_reg[0];
    assign host_rvalid_o = rvalid_reg[1];
    assign rdata_o       = ram_rdata_i;

`ifdef MEMY_ARB_STATS_EN
    logic [15:0] cnt_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg[gi] <= '0;
                else if (gnt_vec[gi] && (cnt_reg[gi] != 16'hFFFF))
                    cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
            end
        end
    endgenerate

    assign core_cnt_o = cnt_reg[0];
    assign host_cnt_o = cnt_reg[1];
`else
    assign core_cnt_o = 16'd0;
    assign host_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_memy_arbiter.sv
// Randomised and directed bench for memy_arbiter against a transaction-level model
// of the arbitration rules and a memory image.
module tb_memy_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, core_lock, host_req, host_we;
    logic [AW-1:0] core_addr, host_addr;
    logic [DW-1:0] core_wdata, host_wdata;
    logic          core_gnt_o, host_gnt_o, core_rvalid_o, host_rvalid_o;
    logic [DW-1:0] rdata_o, ram_wdata_o;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_we_o;
    logic [AW-1:0] ram_waddr_o, ram_raddr_o;
    logic [15:0]   core_cnt_o, host_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memy_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_lock_i(core_lock),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata),
        .core_gnt_o(core_gnt_o), .host_gnt_o(host_gnt_o),
        .core_rvalid_o(core_rvalid_o), .host_rvalid_o(host_rvalid_o),
        .rdata_o(rdata_o), .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o),
        .ram_raddr_o(ram_raddr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata), .core_cnt_o(core_cnt_o), .host_cnt_o(host_cnt_o)
    );

    // memY itself: synchronous write, registered read.
    logic [DW-1:0] ram [16] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_waddr_o] <= ram_wdata_o;
        ram_rdata <= ram[ram_raddr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, who won last, pending reads, memory image.
    logic          m_locked, m_last_host, m_cpend, m_hpend;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_waddr, m_raddr;
    logic [DW-1:0] m_mem [16] = '{default: '0};
    int            m_ccnt, m_hcnt;
    logic          e_cg, e_hg, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    always_comb begin
        e_cg = 1'b0;
        e_hg = 1'b0;
        if (!rst) begin
            if (m_locked)
                e_cg = core_req;
            else if (core_req && host_req)
                // host won last time, so the core takes the tie (and vice versa)
                {e_cg, e_hg} = m_last_host ? 2'b10 : 2'b01;
            else
                {e_cg, e_hg} = {core_req, host_req};
        end
        e_we    = e_cg ? core_we    : host_we;
        e_addr  = e_cg ? core_addr  : host_addr;
        e_wdata = e_cg ? core_wdata : host_wdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked <= 1'b0; m_last_host <= 1'b1; m_cpend <= 1'b0; m_hpend <= 1'b0;
            m_waddr <= '0; m_raddr <= '0; m_rdata <= '0; m_ccnt <= 0; m_hcnt <= 0;
        end else begin
            m_cpend <= e_cg && !e_we;
            m_hpend <= e_hg && !e_we;
            if (e_cg || e_hg) begin
                m_last_host <= e_hg;
                if (e_we) begin
                    m_mem[e_addr] <= e_wdata;
                    m_waddr <= e_addr;
                end else begin
                    m_rdata <= m_mem[e_addr];
                    m_raddr <= e_addr;
                end
            end
            if (m_locked) m_locked <= core_lock;
            else          m_locked <= e_cg && core_lock;
`ifdef MEMY_ARB_STATS_EN
            if (e_cg && m_ccnt < 65535) m_ccnt <= m_ccnt + 1;
            if (e_hg && m_hcnt < 65535) m_hcnt <= m_hcnt + 1;
`endif
        end
    end

    always @(negedge clk) begin
        check("core_gnt", core_gnt_o, e_cg);
        check("host_gnt", host_gnt_o, e_hg);
        check("ram_we", ram_we_o, (e_cg || e_hg) && e_we);
        check("ram_waddr", ram_waddr_o, ((e_cg || e_hg) && e_we) ? e_addr : m_waddr);
        if ((e_cg || e_hg) && e_we) check("ram_wdata", ram_wdata_o, e_wdata);
        check("ram_raddr", ram_raddr_o, ((e_cg || e_hg) && !e_we) ? e_addr : m_raddr);
        check("core_rvalid", core_rvalid_o, m_cpend);
        check("host_rvalid", host_rvalid_o, m_hpend);
        if (m_cpend || m_hpend) check("rdata", rdata_o, m_rdata);
        check("core_cnt", core_cnt_o, m_ccnt);
        check("host_cnt", host_cnt_o, m_hcnt);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic cl, input logic hr,
                         input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd; core_lock = cl;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_state", {core_gnt_o, host_gnt_o, core_rvalid_o, host_rvalid_o, ram_we_o,
                              ram_waddr_o, ram_raddr_o}, 32'd0);
        repeat (2) next_cycle();
        rst = 1'b0;
        $display("txn: both requesting from reset");
        drive(1, 0, 4'd1, 8'h00, 0, 1, 0, 4'd2, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("alt_core", core_gnt_o, (i % 2) == 0);
            check("alt_host", host_gnt_o, (i % 2) == 1);
            next_cycle();
        end

        $display("txn: host write addr 3 data A5");
        drive(0, 0, 0, 0, 0, 1, 1, 4'd3, 8'hA5);
        @(negedge clk);
        check("wr_we", ram_we_o, 1'b1);
        check("wr_addr", ram_waddr_o, 4'd3);
        check("wr_data", ram_wdata_o, 8'hA5);
        next_cycle();
        $display("txn: host read addr 3");
        drive(0, 0, 0, 0, 0, 1, 0, 4'd3, 8'h00);
        @(negedge clk);
        check("rd_gnt", host_gnt_o, 1'b1);
        check("rd_addr", ram_raddr_o, 4'd3);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd_rvalid", host_rvalid_o, 1'b1);
        check("rd_data", rdata_o, 8'hA5);

        next_cycle();
        $display("txn: core lock for 4 cycles with host requesting");
        drive(1, 0, 4'd5, 8'h00, 1, 1, 0, 4'd6, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lock_core", core_gnt_o, 1'b1);
            check("lock_host", host_gnt_o, 1'b0);
            next_cycle();
        end
        core_lock = 1'b0;
        @(negedge clk);
        check("unlock_core", core_gnt_o, 1'b1);
        next_cycle();
        @(negedge clk);
        check("after_lock_host", host_gnt_o, 1'b1);
        check("after_lock_core", core_gnt_o, 1'b0);

        next_cycle();
        $display("txn: reset during granted read");
        drive(0, 0, 0, 0, 0, 1, 0, 4'd3, 8'h00);
        #2 rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_no_rvalid", {core_rvalid_o, host_rvalid_o}, 2'b00);
        next_cycle();
        drive(1, 0, 4'd7, 8'h00, 0, 1, 0, 4'd8, 8'h00);
        @(negedge clk);
        check("rst_tie_core", {core_gnt_o, host_gnt_o}, 2'b10);

        $display("txn: 1500 random cycles");
        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom), DW'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  AW'($urandom), DW'($urandom));
        end

        next_cycle();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        drive(1, 0, 4'd0, 8'h00, 0, 0, 0, 0, 0);
`ifdef MEMY_ARB_STATS_EN
        $display("txn: 70000 core grants");
        repeat (70000) next_cycle();
        @(negedge clk);
        check("core_cnt_sat", core_cnt_o, 16'hFFFF);
        check("host_cnt_zero", host_cnt_o, 16'h0000);
`else
        $display("txn: core grants with counters disabled");
        repeat (300) next_cycle();
        @(negedge clk);
        check("core_cnt_tied", core_cnt_o, 16'h0000);
        check("host_cnt_tied", host_cnt_o, 16'h0000);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
